serial_alu_seq: RTL

//  Bit-serial add / subtract / XOR unit, LSB first, one result bit per clock.

---
 rtl/serial_alu_pkg.sv | 15 +
 rtl/serial_shift_reg.sv | 28 ++
 rtl/serial_alu_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: mode codes and FSM state encoding.
package serial_alu_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    // One state bit per flag-driving state, so busy/done come straight off flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register: parallel load, serial-in at MSB, serial-out at LSB.
module serial_shift_reg #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [N-1:0] din,
    output logic [N-1:0] q,
    output logic         sout
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {sin, q[N-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ADD/SUB/XOR engine, LSB first, with start/busy/done handshake and carry/overflow flags.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          is_xor;
    logic          load, shift, last;
    logic          a_bit, b_bit, s_bit, carry_out;
    logic          sub_req, xor_req;
    logic [N-1:0]  a_par_unused, b_par_unused;
    logic          s_sout_unused;

    assign sub_req = (mode == MODE_SUB);
    assign xor_req = (mode == MODE_XOR);
    assign last    = (cnt == LAST);

    // XOR mode suppresses the carry chain, which also zeroes cout and ovf.
    assign s_bit     = a_bit ^ b_bit ^ (carry & ~is_xor);
    assign carry_out = ~is_xor & ((a_bit & b_bit) | (a_bit & carry) | (b_bit & carry));

    serial_shift_reg #(.N(N)) u_a_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .shift   (shift),
        .sin     (1'b0),
        .din     (a),
        .q       (a_par_unused),
        .sout    (a_bit)
    );

    // Subtraction is a + ~b + 1 (or + 0 with borrow-in), so B is stored inverted.
    serial_shift_reg #(.N(N)) u_b_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .shift   (shift),
        .sin     (1'b0),
        .din     (sub_req ? ~b : b),
        .q       (b_par_unused),
        .sout    (b_bit)
    );

    serial_shift_reg #(.N(N)) u_s_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (1'b0),
        .shift   (shift),
        .sin     (s_bit),
        .din     ('0),
        .q       (sum),
        .sout    (s_sout_unused)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            is_xor <= 1'b0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            carry  <= xor_req ? 1'b0 : (cin ^ sub_req);
            is_xor <= xor_req;
        end else if (shift) begin
            cnt   <= cnt + 1'b1;
            carry <= carry_out;
            if (last) begin
                // carry here is still the carry into the MSB.
                cout <= carry_out;
                ovf  <= carry ^ carry_out;
            end
        end
    end

    assign busy = state[0];
    assign done = state[1];

endmodule
